// File: rtl/hex_scan_pkg.sv
// Shared types and constants for the HEX0 scan sequencer: FSM state codes
// and the active-low glyphs shown for each 2-bit field value.
package hex_scan_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAUSE = 2'd1,
        MAN   = 2'd2
    } scan_state_e;

    localparam logic [6:0] GLYPH_00    = 7'b0100000;
    localparam logic [6:0] GLYPH_01    = 7'b1100011;
    localparam logic [6:0] GLYPH_10    = 7'b0000111;
    localparam logic [6:0] GLYPH_11    = 7'b0100011;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

endpackage

// File: rtl/hex_scan_ctrl_glyph_dec.sv
// Combinational decoder from a 2-bit field value to the active-low
// seven-segment glyph driven onto HEX0.
module glyph_dec
    import hex_scan_pkg::*;
(
    input  logic [1:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = GLYPH_00;
        case (code_i)
            2'd0: seg_o = GLYPH_00;
            2'd1: seg_o = GLYPH_01;
            2'd2: seg_o = GLYPH_10;
            2'd3: seg_o = GLYPH_11;
            default: seg_o = GLYPH_00;
        endcase
    end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Display sequencer: steps the 4:1 field select automatically (RUN/PAUSE) or per
// KEY[1] press (MAN) and drives HEX0/LEDR. Define HEX_SCAN_DEBOUNCE_EN to add a debouncer.
module hex_scan_ctrl
    import hex_scan_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int DB_CYCLES = 500_000
)
(
    input  logic       CLOCK_50,
    input  logic [1:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [9:0] LEDR
);

    localparam int CW  = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    scan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic          sync1_q, sync2_q, prev_q;
    logic [6:0]    hex_q, hex_d;
    logic [1:0]    field_q, field_d;
    logic          tick_q, tick_d;
    logic          level, press, step;

`ifdef HEX_SCAN_DEBOUNCE_EN
    logic           db_q;
    logic [DBW-1:0] db_cnt_q;
    assign level = db_q;
`else
    logic [31:0] unused_db;
    assign unused_db = DB_CYCLES;
    assign level = sync2_q;
`endif

    assign press = prev_q & ~level;

    always_comb begin
        state_d = SW[8] ? MAN : (SW[9] ? PAUSE : RUN);
        tick_d  = (state_d == RUN) && (cnt_q == CW'(TICK_DIV - 1));
        step    = (state_d == MAN) && press;
        cnt_d   = cnt_q;
        // Leaving PAUSE resumes the frozen count; only MAN (and reset) zero it.
        if (state_d == MAN || (state_d == RUN && state_q == MAN)) begin
            cnt_d = '0;
        end else if (state_d == RUN) begin
            cnt_d = tick_d ? '0 : cnt_q + CW'(1);
        end
        sel_d = (tick_d || step) ? sel_q + 2'd1 : sel_q;
        case (sel_q)
            2'd0: field_d = SW[1:0];
            2'd1: field_d = SW[3:2];
            2'd2: field_d = SW[5:4];
            default: field_d = SW[7:6];
        endcase
    end

    glyph_dec u_glyph_dec (
        .code_i (field_d),
        .seg_o  (hex_d)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!KEY[0]) begin
            state_q <= RUN;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            hex_q   <= GLYPH_BLANK;
            field_q <= 2'd0;
            tick_q  <= 1'b0;
`ifdef HEX_SCAN_DEBOUNCE_EN
            db_q     <= 1'b1;
            db_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            sync1_q <= KEY[1];
            sync2_q <= sync1_q;
            prev_q  <= level;
            hex_q   <= hex_d;
            field_q <= field_d;
            tick_q  <= tick_d;
`ifdef HEX_SCAN_DEBOUNCE_EN
            // The debounced level follows only after DB_CYCLES consecutive disagreeing samples.
            if (sync2_q == db_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DBW'(DB_CYCLES - 1)) begin
                db_q     <= sync2_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DBW'(1);
            end
`endif
        end
    end

    assign HEX0 = hex_q;
    assign LEDR = {3'b000, state_q, tick_q, field_q, sel_q};

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl: directed scenarios plus randomized
// switch/key activity, compared every cycle against a cycle-level reference model.
module tb_hex_scan_ctrl;

    localparam int TD = 4;
    localparam int DB = 3;

    logic       clk = 1'b0;
    logic [1:0] key;
    logic [9:0] sw;
    logic [6:0] hex;
    logic [9:0] ledr;

    always #5 clk = ~clk;

    hex_scan_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
        .CLOCK_50 (clk),
        .KEY      (key),
        .SW       (sw),
        .HEX0     (hex),
        .LEDR     (ledr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: mode 0=auto running, 1=auto paused, 2=manual.
    logic [6:0] glyph_tbl [4] = '{7'b0100000, 7'b1100011, 7'b0000111, 7'b0100011};
    int         m_mode, m_cnt, m_sel;
    logic [6:0] m_hex;
    logic [9:0] m_led;
    bit         khist [8];   // khist[i] = KEY[1] as sampled i+1 edges ago
    bit         m_db, m_db_prev;

    task automatic model_step();
        int nmode, fld, new_sel;
        bit press, tick, step, flip;
        if (!key[0]) begin
            m_mode = 0; m_cnt = 0; m_sel = 0;
            m_hex = 7'h7F; m_led = '0;
            for (int i = 0; i < 8; i++) khist[i] = 1'b1;
            m_db = 1'b1; m_db_prev = 1'b1;
            return;
        end
        nmode = sw[8] ? 2 : (sw[9] ? 1 : 0);
`ifdef HEX_SCAN_DEBOUNCE_EN
        press = m_db_prev && !m_db;
        flip = 1'b1;
        for (int i = 1; i <= DB; i++) if (khist[i] == m_db) flip = 1'b0;
        m_db_prev = m_db;
        if (flip) m_db = !m_db;
`else
        press = khist[2] && !khist[1];
`endif
        tick = (nmode == 0) && (m_mode != 2) && (m_cnt == TD - 1);
        if (nmode == 0 && m_mode != 2) m_cnt = (m_cnt + 1) % TD;
        else if (nmode != 1)           m_cnt = 0;
        step    = (nmode == 2) && press;
        fld     = (sw >> (2 * m_sel)) & 3;
        new_sel = (m_sel + ((tick || step) ? 1 : 0)) % 4;
        m_hex   = glyph_tbl[fld];
        m_led   = {3'b000, 2'(nmode), tick, 2'(fld), 2'(new_sel)};
        m_sel   = new_sel;
        m_mode  = nmode;
        for (int i = 7; i > 0; i--) khist[i] = khist[i-1];
        khist[0] = key[1];
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("hex0", {25'd0, hex}, {25'd0, m_hex});
        check_eq("ledr", {22'd0, ledr}, {22'd0, m_led});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic press_key(input int low_cycles, input int high_cycles);
        key[1] = 1'b0;
        run(low_cycles);
        key[1] = 1'b1;
        run(high_cycles);
    endtask

    int   n, ticks, found, key_left;
    logic [1:0] sel_b;

    initial begin
        key = 2'b10;
        sw  = 10'h0E4;
        // Reset held for two edges
        run(2);
        check_eq("rst_hex", {25'd0, hex}, 32'h7F);
        check_eq("rst_ledr", {22'd0, ledr}, 32'd0);
        key[0] = 1'b1;
        cycle();
        check_eq("post_rst_sel", {30'd0, ledr[1:0]}, 32'd0);
        check_eq("post_rst_hex", {25'd0, hex}, {25'd0, 7'b0100000});

        // Auto wrap: one tick every TD cycles
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (ledr[4]) ticks++;
        end
        check_eq("auto_ticks", ticks, 5);

        // Pause mid-count at sel=2, then resume
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (m_sel == 2 && m_cnt == 1) found = 1;
        end
        check_eq("pause_reach", found, 1);
        sw[9] = 1'b1;
        run(8);
        check_eq("pause_sel", {30'd0, ledr[1:0]}, 32'd2);
        sw[9] = 1'b0;
        n = 0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            n++;
            if (ledr[1:0] == 2'd3) found = 1;
        end
        check_eq("resume_latency", n, TD - 1);

        // Manual: three presses advance exactly three
        sw[8] = 1'b1;
        run(2);
        sel_b = ledr[1:0];
        for (int i = 0; i < 3; i++) press_key(10, 10);
        check_eq("man_steps", {30'd0, ledr[1:0]}, {30'd0, sel_b + 2'd3});

        // A press outside manual mode is discarded
        sw[9:8] = 2'b10;
        run(2);
        sel_b = ledr[1:0];
        press_key(10, 10);
        check_eq("pause_press", {30'd0, ledr[1:0]}, {30'd0, sel_b});

        // Mode switch to MAN on the would-be tick cycle
        sw[9:8] = 2'b00;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (m_cnt == TD - 1) found = 1;
        end
        check_eq("simul_reach", found, 1);
        sel_b = ledr[1:0];
        sw[8] = 1'b1;
        cycle();
        check_eq("simul_sel", {30'd0, ledr[1:0]}, {30'd0, sel_b});
        check_eq("simul_state", {30'd0, ledr[6:5]}, 32'd2);
        check_eq("simul_tick", {31'd0, ledr[4]}, 32'd0);
        run(3);
        // Back to RUN: entry edge plus TD counted edges before the first tick
        sw[8] = 1'b0;
        n = 0;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            cycle();
            n++;
            if (ledr[4]) found = 1;
        end
        check_eq("run_entry_tick", n, TD + 1);

        // Short glitch versus a held press
        sw[8] = 1'b1;
        run(4);
        sel_b = ledr[1:0];
        press_key(2, 12);
`ifdef HEX_SCAN_DEBOUNCE_EN
        check_eq("glitch", {30'd0, ledr[1:0]}, {30'd0, sel_b});
`else
        check_eq("glitch", {30'd0, ledr[1:0]}, {30'd0, sel_b + 2'd1});
`endif
        sel_b = ledr[1:0];
        press_key(5, 12);
        check_eq("held_press", {30'd0, ledr[1:0]}, {30'd0, sel_b + 2'd1});

        // Randomized activity, including occasional resets
        key_left = 1;
        for (int i = 0; i < 500; i++) begin
            key[0] = ($urandom % 64) != 0;
            if ($urandom % 20 == 0) sw[9:8] = 2'($urandom);
            if ($urandom % 5 == 0)  sw[7:0] = 8'($urandom);
            key_left--;
            if (key_left <= 0) begin
                key[1]   = ~key[1];
                key_left = $urandom_range(1, 8);
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
